// File: rtl/ghash_accumulator_pkg.sv
// Shared constants and state encoding for the GHASH accumulator.
package ghash_accumulator_pkg;

    // Width of the multiplier watchdog counter.
    localparam int unsigned MULT_TIMEOUT_W = 11;

    // GF(2^128) field polynomial x^128 + x^7 + x^2 + x + 1.
    localparam logic [128:0] GF128_POLY = {1'b1, 120'h0, 8'h87};

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } ghash_state_e;

endpackage

// File: rtl/gf_bit_reverse.sv
// Combinational bit-order reversal between GCM bit order and polynomial order.
module gf_bit_reverse #(
    parameter int unsigned DEGREE = 128
) (
    input  logic [DEGREE-1:0] data_i,
    output logic [DEGREE-1:0] data_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DEGREE; gi++) begin : g_rev
            assign data_o[gi] = data_i[DEGREE-1-gi];
        end
    endgenerate

endmodule

// File: rtl/ghash_accumulator.sv
// GHASH accumulator: Y_i = (Y_{i-1} ^ X_i) * H, driving an external GF(2^DEGREE)
// multiplier over a go/finished handshake and publishing the tag on the last block.
module ghash_accumulator
    import ghash_accumulator_pkg::*;
#(
    parameter int unsigned DEGREE       = 128,
    parameter bit          REFLECT      = 1'b1,
    parameter int unsigned MULT_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              h_load,
    input  logic [DEGREE-1:0] h_key,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DEGREE-1:0] in_data,
    input  logic              in_last,
    output logic              tag_valid,
    output logic [DEGREE-1:0] tag_data,
    output logic              busy,
    output logic              err,
    output logic              mult_go,
    output logic [DEGREE-1:0] mult_x,
    output logic [DEGREE-1:0] mult_y,
    input  logic [DEGREE-1:0] mult_result,
    input  logic              mult_finished
);

    localparam logic [DEGREE-1:0]         ZERO_BLK    = {DEGREE{1'b0}};
    localparam logic [MULT_TIMEOUT_W-1:0] TIMER_ONE   = MULT_TIMEOUT_W'(1);
    localparam logic [MULT_TIMEOUT_W-1:0] TIMEOUT_CNT = MULT_TIMEOUT_W'(MULT_TIMEOUT);

    ghash_state_e              state_q, state_d;
    logic [DEGREE-1:0]         y_q, y_d;
    logic                      h_ok_q, h_ok_d;
    logic                      err_q, err_d;
    logic                      last_q, last_d;
    logic                      fin_q;
    logic [MULT_TIMEOUT_W-1:0] timer_q, timer_d;
    logic                      mult_go_q, mult_go_d;
    logic [DEGREE-1:0]         mult_x_q, mult_x_d;
    logic [DEGREE-1:0]         mult_y_q, mult_y_d;
    logic                      tag_valid_q, tag_valid_d;
    logic [DEGREE-1:0]         tag_data_q, tag_data_d;

    logic                      in_ready_s;
    logic                      rise_s;
    logic [MULT_TIMEOUT_W-1:0] timer_inc_s;
    logic [DEGREE-1:0]         x_plain_s, x_rev_s, x_sel_s;
    logic [DEGREE-1:0]         h_rev_s, h_sel_s;
    logic [DEGREE-1:0]         res_rev_s, res_sel_s;

    // Operand/result bit-order conversion; pass-through when REFLECT is 0.
    assign x_plain_s = y_q ^ in_data;

    gf_bit_reverse #(.DEGREE(DEGREE)) u_rev_x (.data_i(x_plain_s),   .data_o(x_rev_s));
    gf_bit_reverse #(.DEGREE(DEGREE)) u_rev_y (.data_i(h_key),       .data_o(h_rev_s));
    gf_bit_reverse #(.DEGREE(DEGREE)) u_rev_r (.data_i(mult_result), .data_o(res_rev_s));

    assign x_sel_s   = REFLECT ? x_rev_s   : x_plain_s;
    assign h_sel_s   = REFLECT ? h_rev_s   : h_key;
    assign res_sel_s = REFLECT ? res_rev_s : mult_result;

    // Only a fresh rising edge of finished completes an operation; a level left
    // high by an earlier (possibly aborted) operation is ignored.
    assign rise_s      = mult_finished & ~fin_q;
    assign timer_inc_s = timer_q + TIMER_ONE;

    // Next-state, datapath update and handshake decode.
    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        h_ok_d      = h_ok_q;
        err_d       = err_q;
        last_d      = last_q;
        timer_d     = timer_q;
        mult_go_d   = 1'b0;
        mult_x_d    = mult_x_q;
        mult_y_d    = mult_y_q;
        tag_valid_d = 1'b0;
        tag_data_d  = tag_data_q;
        in_ready_s  = 1'b0;

        if (clear) begin
            y_d     = ZERO_BLK;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A key load takes the cycle; no block can be accepted with it.
                    in_ready_s = h_ok_q & ~h_load;
                    if (h_load) begin
                        mult_y_d = h_sel_s;
                        h_ok_d   = 1'b1;
                        y_d      = ZERO_BLK;
                        err_d    = 1'b0;
                    end else if (in_valid && in_ready_s) begin
                        mult_x_d  = x_sel_s;
                        last_d    = in_last;
                        mult_go_d = 1'b1;
                        state_d   = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // The go cycle itself counts toward the watchdog budget.
                    timer_d = TIMER_ONE;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    timer_d = timer_inc_s;
                    if (rise_s) begin
                        if (last_q) begin
                            tag_data_d  = res_sel_s;
                            tag_valid_d = 1'b1;
                            y_d         = ZERO_BLK;
                        end else begin
                            y_d = res_sel_s;
                        end
                        state_d = ST_IDLE;
                    end else if (timer_inc_s == TIMEOUT_CNT) begin
                        err_d   = 1'b1;
                        y_d     = ZERO_BLK;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    y_d     = ZERO_BLK;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            y_q         <= ZERO_BLK;
            h_ok_q      <= 1'b0;
            err_q       <= 1'b0;
            last_q      <= 1'b0;
            fin_q       <= 1'b0;
            timer_q     <= {MULT_TIMEOUT_W{1'b0}};
            mult_go_q   <= 1'b0;
            mult_x_q    <= ZERO_BLK;
            mult_y_q    <= ZERO_BLK;
            tag_valid_q <= 1'b0;
            tag_data_q  <= ZERO_BLK;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            h_ok_q      <= h_ok_d;
            err_q       <= err_d;
            last_q      <= last_d;
            fin_q       <= mult_finished;
            timer_q     <= timer_d;
            mult_go_q   <= mult_go_d;
            mult_x_q    <= mult_x_d;
            mult_y_q    <= mult_y_d;
            tag_valid_q <= tag_valid_d;
            tag_data_q  <= tag_data_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign mult_go   = mult_go_q;
    assign mult_x    = mult_x_q;
    assign mult_y    = mult_y_q;
    assign tag_valid = tag_valid_q;
    assign tag_data  = tag_data_q;

endmodule

// File: tb/tb_ghash_accumulator.sv
// Bench for ghash_accumulator: one instance in polynomial order (REFLECT=0) and one in
// GCM bit order (REFLECT=1) share all inputs; each has its own behavioural multiplier.
module tb_ghash_accumulator;
    import ghash_accumulator_pkg::*;

    localparam int TMO = 1023;

    logic clk = 1'b0;
    logic rst_n, h_load, clear, in_valid, in_last;
    logic [127:0] h_key, in_data;

    logic [1:0]   in_ready, tag_valid, busy, err, m_go, m_fin, m_busy;
    logic [127:0] tag_data [2];
    logic [127:0] m_x [2];
    logic [127:0] m_y [2];
    logic [127:0] m_res [2];
    int           m_cnt [2];

    bit stub_hold;
    int mult_lat;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [127:0] tq0[$];
    logic [127:0] tq1[$];
    int rd0 = 0;
    int rd1 = 0;

    logic [127:0] h_m, y_m0, y_m1, exp_t0, exp_t1;

    ghash_accumulator #(.DEGREE(128), .REFLECT(1'b0), .MULT_TIMEOUT(TMO)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .h_load(h_load), .h_key(h_key), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data), .in_last(in_last),
        .tag_valid(tag_valid[0]), .tag_data(tag_data[0]), .busy(busy[0]), .err(err[0]),
        .mult_go(m_go[0]), .mult_x(m_x[0]), .mult_y(m_y[0]),
        .mult_result(m_res[0]), .mult_finished(m_fin[0])
    );

    ghash_accumulator #(.DEGREE(128), .REFLECT(1'b1), .MULT_TIMEOUT(TMO)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .h_load(h_load), .h_key(h_key), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data), .in_last(in_last),
        .tag_valid(tag_valid[1]), .tag_data(tag_data[1]), .busy(busy[1]), .err(err[1]),
        .mult_go(m_go[1]), .mult_x(m_x[1]), .mult_y(m_y[1]),
        .mult_result(m_res[1]), .mult_finished(m_fin[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in (polynomial order, shift-and-add).
    function automatic logic [127:0] gf_mul_poly(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] z, v;
        z = 128'h0;
        v = a;
        for (int i = 0; i < 128; i++) begin
            if (b[i]) z = z ^ v;
            v = v[127] ? ((v << 1) ^ 128'h87) : (v << 1);
        end
        return z;
    endfunction

    // Reference: full carry-less product, then reduction by the field polynomial.
    function automatic logic [127:0] ref_mul_poly(input logic [127:0] a, input logic [127:0] b);
        logic [254:0] p;
        p = 255'h0;
        for (int i = 0; i < 128; i++)
            if (b[i]) p = p ^ ({127'h0, a} << i);
        for (int i = 254; i >= 128; i--)
            if (p[i]) p = p ^ ({126'h0, GF128_POLY} << (i - 128));
        return p[127:0];
    endfunction

    // Reference: GCM-order multiply (MSB is the x^0 coefficient, R = 0xE1 || 0^120).
    function automatic logic [127:0] ref_mul_gcm(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] z, v;
        z = 128'h0;
        v = a;
        for (int i = 0; i < 128; i++) begin
            if (b[127 - i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'hE1, 120'h0}) : (v >> 1);
        end
        return z;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural multipliers: finished rises mult_lat cycles after go is seen.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fin  <= 2'b00;
            m_busy <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] <= 0;
                m_res[k] <= 128'h0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_go[k]) begin
                    m_busy[k] <= 1'b1;
                    m_cnt[k]  <= 1;
                    m_fin[k]  <= 1'b0;
                    m_res[k]  <= gf_mul_poly(m_x[k], m_y[k]);
                end else if (m_busy[k] && !stub_hold) begin
                    if (m_cnt[k] >= mult_lat) begin
                        m_fin[k]  <= 1'b1;
                        m_busy[k] <= 1'b0;
                    end else begin
                        m_cnt[k] <= m_cnt[k] + 1;
                    end
                end
            end
        end
    end

    // Tag monitor: one entry per cycle of tag_valid.
    always @(negedge clk) begin
        if (tag_valid[0]) tq0.push_back(tag_data[0]);
        if (tag_valid[1]) tq1.push_back(tag_data[1]);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_h(input logic [127:0] k);
        @(negedge clk);
        h_load = 1'b1;
        h_key  = k;
        @(negedge clk);
        h_load = 1'b0;
        h_m  = k;
        y_m0 = 128'h0;
        y_m1 = 128'h0;
    endtask

    task automatic send_block(input logic [127:0] x, input logic last);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        in_last  = last;
        #1;
        n = 0;
        while (in_ready !== 2'b11 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL accept_wait: in_ready=%b required 11 within 100 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 2'b00 && n < 300);
        #1;
        checks++;
        if (busy !== 2'b00) begin
            errors++;
            $display("FAIL done_wait: busy=%b required 00 within 300 cycles", busy);
        end
    endtask

    task automatic run_block(input logic [127:0] x, input logic last);
        send_block(x, last);
        y_m0 = ref_mul_poly(y_m0 ^ x, h_m);
        y_m1 = ref_mul_gcm(y_m1 ^ x, h_m);
        if (last) begin
            exp_t0 = y_m0;
            exp_t1 = y_m1;
            y_m0 = 128'h0;
            y_m1 = 128'h0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; h_load = 1'b0; h_key = 128'h0; clear = 1'b0;
        in_valid = 1'b0; in_data = 128'h0; in_last = 1'b0;
        stub_hold = 1'b0; mult_lat = 4;
        h_m = 128'h0; y_m0 = 128'h0; y_m1 = 128'h0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({in_ready[k], tag_valid[k], busy[k], err[k], m_go[k]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl%0d: rdy/tv/busy/err/go=%b required 00000", k,
                         {in_ready[k], tag_valid[k], busy[k], err[k], m_go[k]});
            end
            checks++;
            if ({tag_data[k], m_x[k], m_y[k]} !== 384'h0) begin
                errors++;
                $display("FAIL reset_data%0d: tag=%h x=%h y=%h required 0", k,
                         tag_data[k], m_x[k], m_y[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_no_key();
        bit bad;
        bad = 1'b0;
        in_valid = 1'b1;
        in_data  = rand128();
        in_last  = 1'b1;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (in_ready !== 2'b00 || m_go !== 2'b00 || busy !== 2'b00) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_key_accept: in_ready/go/busy rose before h_load, required never");
        end
        @(negedge clk);
        h_load = 1'b1;
        h_key  = 128'h1;
        #1;
        checks++;
        if (in_ready !== 2'b00) begin
            errors++;
            $display("FAIL hload_ready: in_ready=%b required 00", in_ready);
        end
        @(negedge clk);
        h_load   = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 2'b00 || m_go !== 2'b00) begin
            errors++;
            $display("FAIL hload_accept: busy=%b go=%b required 00/00", busy, m_go);
        end
        h_m = 128'h1; y_m0 = 128'h0; y_m1 = 128'h0;
    endtask

    task automatic test_basic();
        load_h(128'h1);
        run_block(128'h5, 1'b0);
        run_block(128'h3, 1'b1);
        checks++;
        if (tq0.size() != rd0 + 1 || tq1.size() != rd1 + 1) begin
            errors++;
            $display("FAIL basic_tag_count: got %0d/%0d pulses required 1/1",
                     tq0.size() - rd0, tq1.size() - rd1);
        end
        checks++;
        if (tq0[rd0] !== 128'h6) begin
            errors++;
            $display("FAIL basic_tag0: got %h required %h", tq0[rd0], 128'h6);
        end
        checks++;
        if (tq1[rd1] !== exp_t1) begin
            errors++;
            $display("FAIL basic_tag1: got %h required %h", tq1[rd1], exp_t1);
        end
        rd0 = tq0.size(); rd1 = tq1.size();
        @(negedge clk);
        checks++;
        if (tag_valid !== 2'b00 || tag_data[0] !== 128'h6) begin
            errors++;
            $display("FAIL basic_tag_hold: tv=%b tag0=%h required 00/%h", tag_valid, tag_data[0], 128'h6);
        end
        run_block(128'h7, 1'b1);
        checks++;
        if (tq0.size() != rd0 + 1 || tq0[rd0] !== 128'h7) begin
            errors++;
            $display("FAIL basic_y_cleared: got %h required %h", tq0[rd0], 128'h7);
        end
        rd0 = tq0.size(); rd1 = tq1.size();
    endtask

    task automatic test_reduction_reflect();
        logic [127:0] b;
        b = 128'h1 << 127;
        load_h(128'h2);
        run_block(b, 1'b1);
        checks++;
        if (tq0.size() != rd0 + 1 || tq0[rd0] !== 128'h87) begin
            errors++;
            $display("FAIL reduce_tag0: got %h required %h", tq0[rd0], 128'h87);
        end
        checks++;
        if (tq1.size() != rd1 + 1 || tq1[rd1] !== exp_t1) begin
            errors++;
            $display("FAIL reduce_tag1: got %h required %h", tq1[rd1], exp_t1);
        end
        rd0 = tq0.size(); rd1 = tq1.size();
        load_h(128'h8000_0000_0000_0000_0000_0000_0000_0000);
        run_block(128'hDEADBEEF, 1'b1);
        checks++;
        if (tq1.size() != rd1 + 1 || tq1[rd1] !== 128'hDEADBEEF) begin
            errors++;
            $display("FAIL reflect_tag1: got %h required %h", tq1[rd1], 128'hDEADBEEF);
        end
        checks++;
        if (tq0.size() != rd0 + 1 || tq0[rd0] !== exp_t0) begin
            errors++;
            $display("FAIL reflect_tag0: got %h required %h", tq0[rd0], exp_t0);
        end
        rd0 = tq0.size(); rd1 = tq1.size();
    endtask

    task automatic test_random_messages();
        int len;
        logic [127:0] prev0;
        load_h(rand128());
        prev0 = tag_data[0];
        for (int m = 0; m < 6; m++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                mult_lat = $urandom_range(1, 8);
                run_block(rand128(), (b == len - 1));
                if (b == len - 1) begin
                    checks++;
                    if (tq0.size() != rd0 + 1 || tq0[rd0] !== exp_t0) begin
                        errors++;
                        $display("FAIL rand_tag0 m%0d: got %h required %h", m, tq0[rd0], exp_t0);
                    end
                    checks++;
                    if (tq1.size() != rd1 + 1 || tq1[rd1] !== exp_t1) begin
                        errors++;
                        $display("FAIL rand_tag1 m%0d: got %h required %h", m, tq1[rd1], exp_t1);
                    end
                    prev0 = exp_t0;
                end else begin
                    checks++;
                    if (tq0.size() != rd0 || tag_data[0] !== prev0) begin
                        errors++;
                        $display("FAIL rand_mid_tag m%0d: tag0=%h pulses=%0d required %h/0", m,
                                 tag_data[0], tq0.size() - rd0, prev0);
                    end
                end
                rd0 = tq0.size(); rd1 = tq1.size();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] xs [8];
        logic         ls [8];
        int           acc [8];
        logic [127:0] e0[$];
        logic [127:0] e1[$];
        int n;
        mult_lat = $urandom_range(2, 6);
        load_h(rand128());
        for (int k = 0; k < 8; k++) begin
            xs[k] = rand128();
            ls[k] = (k == 7) ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = xs[k];
            in_last  = ls[k];
            #1;
            n = 0;
            while (in_ready !== 2'b11 && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            checks++;
            if (n >= 100) begin
                errors++;
                $display("FAIL b2b_accept_wait: block %0d not accepted", k);
            end
            acc[k] = cyc + 1;
            y_m0 = ref_mul_poly(y_m0 ^ xs[k], h_m);
            y_m1 = ref_mul_gcm(y_m1 ^ xs[k], h_m);
            if (ls[k]) begin
                e0.push_back(y_m0);
                e1.push_back(y_m1);
                y_m0 = 128'h0;
                y_m1 = 128'h0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 2'b00 && n < 300);
        #1;
        for (int k = 1; k < 8; k++) begin
            checks++;
            if (acc[k] - acc[k-1] != mult_lat + 3) begin
                errors++;
                $display("FAIL b2b_spacing %0d: got %0d cycles required %0d", k,
                         acc[k] - acc[k-1], mult_lat + 3);
            end
        end
        checks++;
        if (tq0.size() - rd0 != e0.size() || tq1.size() - rd1 != e1.size()) begin
            errors++;
            $display("FAIL b2b_tag_count: got %0d/%0d required %0d",
                     tq0.size() - rd0, tq1.size() - rd1, e0.size());
        end
        for (int i = 0; i < e0.size(); i++) begin
            checks++;
            if (tq0[rd0 + i] !== e0[i] || tq1[rd1 + i] !== e1[i]) begin
                errors++;
                $display("FAIL b2b_tag %0d: got %h/%h required %h/%h", i,
                         tq0[rd0 + i], tq1[rd1 + i], e0[i], e1[i]);
            end
        end
        rd0 = tq0.size(); rd1 = tq1.size();
        mult_lat = 4;
    endtask

    task automatic test_clear();
        bit bad;
        int n;
        mult_lat = 30;
        load_h(128'h1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rand128();
        in_last  = 1'b1;
        #1;
        n = 0;
        while (in_ready !== 2'b11 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 2'b11) begin
            errors++;
            $display("FAIL clear_pre_busy: busy=%b required 11", busy);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        checks++;
        if (busy !== 2'b00 || in_ready !== 2'b11) begin
            errors++;
            $display("FAIL clear_idle: busy=%b in_ready=%b required 00/11", busy, in_ready);
        end
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (busy !== 2'b00 || tag_valid !== 2'b00) bad = 1'b1;
        end
        checks++;
        if (bad || tq0.size() != rd0) begin
            errors++;
            $display("FAIL clear_late_finish: busy/tag activity after abort, required none");
        end
        y_m0 = 128'h0; y_m1 = 128'h0;
        mult_lat = 4;
        run_block(128'h9, 1'b1);
        checks++;
        if (tq0.size() != rd0 + 1 || tq0[rd0] !== 128'h9) begin
            errors++;
            $display("FAIL clear_next_tag0: got %h required %h", tq0[rd0], 128'h9);
        end
        checks++;
        if (tq1.size() != rd1 + 1 || tq1[rd1] !== exp_t1) begin
            errors++;
            $display("FAIL clear_next_tag1: got %h required %h", tq1[rd1], exp_t1);
        end
        rd0 = tq0.size(); rd1 = tq1.size();
    endtask

    task automatic test_timeout();
        int n, go_cyc;
        load_h(rand128());
        stub_hold = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rand128();
        in_last  = 1'b1;
        #1;
        n = 0;
        while (in_ready !== 2'b11 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        go_cyc = cyc;
        checks++;
        if (m_go !== 2'b11) begin
            errors++;
            $display("FAIL tmo_go: mult_go=%b required 11", m_go);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_go !== 2'b00) begin
            errors++;
            $display("FAIL tmo_go_width: mult_go=%b required 00 one cycle later", m_go);
        end
        n = 0;
        while (err[0] !== 1'b1 && n < 1200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (cyc - go_cyc != TMO || err !== 2'b11) begin
            errors++;
            $display("FAIL tmo_delay: err=%b after %0d cycles required 11 after %0d", err,
                     cyc - go_cyc, TMO);
        end
        @(negedge clk);
        checks++;
        if (busy !== 2'b00 || tq0.size() != rd0 || tq1.size() != rd1) begin
            errors++;
            $display("FAIL tmo_idle: busy=%b tags=%0d required 00/0", busy, tq0.size() - rd0);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 2'b11) begin
            errors++;
            $display("FAIL tmo_sticky: err=%b required 11", err);
        end
        stub_hold = 1'b0;
        load_h(rand128());
        #1;
        checks++;
        if (err !== 2'b00 || in_ready !== 2'b11) begin
            errors++;
            $display("FAIL tmo_hload_clear: err=%b in_ready=%b required 00/11", err, in_ready);
        end
    endtask

    task automatic test_async_reset();
        int n;
        mult_lat = 20;
        load_h(rand128());
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rand128();
        in_last  = 1'b1;
        #1;
        n = 0;
        while (in_ready !== 2'b11 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 2'b00 || m_go !== 2'b00 || m_x[0] !== 128'h0 || m_y[1] !== 128'h0) begin
            errors++;
            $display("FAIL async_reset: busy=%b go=%b x0=%h y1=%h required 00/00/0/0",
                     busy, m_go, m_x[0], m_y[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_key: in_ready=%b required 00", in_ready);
        end
        mult_lat = 4;
    endtask

    initial begin
        test_reset();
        test_no_key();
        test_basic();
        test_reduction_reflect();
        test_random_messages();
        test_back_to_back();
        test_clear();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
